// File: rtl/link_frame_rx_if.sv
// Link-side signal bundle for the inter-board frame receiver: the raw line pin
// plus the recovered word and status flags presented to game logic.
interface link_frame_rx_if #(
  parameter int DATA_W = 12
);
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              link_ok;
  logic              busy;

  // master drives the line and observes results; slave is the receiver itself
  modport master (
    output rx_in,
    input  data_out, data_valid, frame_err, link_ok, busy
  );

  modport slave (
    input  rx_in,
    output data_out, data_valid, frame_err, link_ok, busy
  );
endinterface

// File: rtl/link_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, even parity, stop bit.
// Holds the last good word and reports link liveness via a saturating timeout.
module link_frame_rx #(
  parameter int DATA_W       = 12,
  parameter int CLKS_PER_BIT = 1000,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  link_frame_rx_if.slave  link
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0]  TO_PRE    = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_reg;
  logic              sync1_reg;
  logic              sync2_reg;
  logic              rx_prev_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              frame_err_reg;
  logic              link_ok_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  logic bit_done;
  logic good_frame;

  assign bit_done   = (timer_reg == BIT_LAST);
  // Stop sample with a high line and even overall parity is a good frame
  assign good_frame = (state_reg == STOP) && bit_done && sync2_reg &&
                      ((^shift_reg ^ parity_reg) == 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= link.rx_in;
      sync2_reg   <= sync1_reg;
      rx_prev_reg <= sync2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Only a genuine high-to-low transition arms a frame
          if (rx_prev_reg && !sync2_reg) begin
            timer_reg <= '0;
            state_reg <= START;
          end
        end
        START: begin
          if (timer_reg == HALF_LAST) begin
            if (sync2_reg) begin
              state_reg <= IDLE;
            end else begin
              timer_reg <= '0;
              idx_reg   <= '0;
              state_reg <= DATA;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg[idx_reg] <= sync2_reg;
            timer_reg          <= '0;
            if (idx_reg == IDX_LAST) begin
              state_reg <= PARITY;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            parity_reg <= sync2_reg;
            timer_reg  <= '0;
            state_reg  <= STOP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            timer_reg <= '0;
            state_reg <= IDLE;
            if (good_frame) begin
              data_out_reg   <= shift_reg;
              data_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // link_ok drops as the counter steps onto TIMEOUT_CLKS; a good frame always wins
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_reg  <= '0;
      link_ok_reg <= 1'b0;
    end else if (good_frame) begin
      to_cnt_reg  <= '0;
      link_ok_reg <= 1'b1;
    end else if (to_cnt_reg != TO_MAX) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
      if (to_cnt_reg == TO_PRE) begin
        link_ok_reg <= 1'b0;
      end
    end
  end

  assign link.data_out   = data_out_reg;
  assign link.data_valid = data_valid_reg;
  assign link.frame_err  = frame_err_reg;
  assign link.link_ok    = link_ok_reg;
  assign link.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_link_frame_rx.sv
// Bench for link_frame_rx: frames are driven bit by bit, good words are queued
// when sent and matched against each data_valid pulse.
module tb_link_frame_rx;

  localparam int DW  = 12;
  localparam int CPB = 16;
  localparam int TO  = 1000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  int   dv_count;
  int   err_count;
  int   dv_cyc;
  logic lk_at_dv;
  logic [DW-1:0] exp_q[$];

  link_frame_rx_if #(.DATA_W(DW)) lif ();

  link_frame_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .link (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every data_valid must match the oldest queued word
  always @(negedge clk) begin
    if (!reset && (lif.data_valid || lif.frame_err)) begin
      checks = checks + 1;
      if (lif.data_valid && lif.frame_err) begin
        errors = errors + 1;
        $display("FAIL excl: data_valid=%b frame_err=%b required not both", lif.data_valid, lif.frame_err);
      end
      if (lif.data_valid) begin
        dv_count = dv_count + 1;
        dv_cyc   = cyc;
        lk_at_dv = lif.link_ok;
        checks   = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected: data_out=%h with no word expected", lif.data_out);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (lif.data_out !== e) begin
            errors = errors + 1;
            $display("FAIL sb_data: data_out=%h required %h", lif.data_out, e);
          end else begin
            $display("frame ok: data_out=%h", lif.data_out);
          end
        end
      end
      if (lif.frame_err) begin
        err_count = err_count + 1;
        $display("frame error pulse at cycle %0d", cyc);
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    lif.rx_in = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    if (stop && ((^d ^ par) == 1'b0)) exp_q.push_back(d);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    lif.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    checks = checks + 1;
    if ({lif.data_out, lif.data_valid, lif.frame_err, lif.link_ok, lif.busy} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outs: data_out=%h dv=%b fe=%b lk=%b busy=%b required all 0",
               lif.data_out, lif.data_valid, lif.frame_err, lif.link_ok, lif.busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_parity_error();
    int dv0, fe0;
    dv0 = dv_count; fe0 = err_count;
    send_frame(12'hA5C, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks = checks + 3;
    if (err_count !== fe0 + 1) begin
      errors = errors + 1;
      $display("FAIL parity_err_cnt: pulses=%0d required 1", err_count - fe0);
    end
    if (dv_count !== dv0) begin
      errors = errors + 1;
      $display("FAIL parity_no_dv: pulses=%0d required 0", dv_count - dv0);
    end
    if (lif.data_out !== 12'h000) begin
      errors = errors + 1;
      $display("FAIL parity_hold: data_out=%h required 000", lif.data_out);
    end
  endtask

  task automatic test_good_frame();
    int dv0, fe0;
    dv0 = dv_count; fe0 = err_count;
    send_frame(12'hA5C, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks = checks + 4;
    if (dv_count !== dv0 + 1) begin
      errors = errors + 1;
      $display("FAIL good_dv: pulses=%0d required 1", dv_count - dv0);
    end
    if (err_count !== fe0) begin
      errors = errors + 1;
      $display("FAIL good_no_err: pulses=%0d required 0", err_count - fe0);
    end
    if (lif.data_out !== 12'hA5C) begin
      errors = errors + 1;
      $display("FAIL good_data: data_out=%h required a5c", lif.data_out);
    end
    if (lif.link_ok !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL good_link: link_ok=%b required 1", lif.link_ok);
    end
  endtask

  task automatic test_stop_fail();
    int fe0, dv0;
    logic busy_seen;
    fe0 = err_count; dv0 = dv_count;
    send_frame(12'h3C3, 1'b0, 1'b0);
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (lif.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks = checks + 3;
    if (err_count !== fe0 + 1) begin
      errors = errors + 1;
      $display("FAIL stop_err: pulses=%0d required 1", err_count - fe0);
    end
    if (busy_seen !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL stop_rearm: busy went high=%b while line low, required 0", busy_seen);
    end
    if (lif.data_out !== 12'hA5C) begin
      errors = errors + 1;
      $display("FAIL stop_hold: data_out=%h required a5c", lif.data_out);
    end
    lif.rx_in = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(12'h001, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks = checks + 2;
    if (lif.data_out !== 12'h001) begin
      errors = errors + 1;
      $display("FAIL stop_recover: data_out=%h required 001", lif.data_out);
    end
    if (dv_count !== dv0 + 1) begin
      errors = errors + 1;
      $display("FAIL stop_recover_dv: pulses=%0d required 1", dv_count - dv0);
    end
  endtask

  task automatic test_glitch();
    int dv0, fe0;
    logic idle_ok;
    dv0 = dv_count; fe0 = err_count;
    @(negedge clk);
    lif.rx_in = 1'b0;
    repeat (4) @(negedge clk);
    lif.rx_in = 1'b1;
    idle_ok = 1'b0;
    for (int i = 0; i < 10 && !idle_ok; i++) begin
      @(negedge clk);
      if (lif.busy === 1'b0 && i >= 3) idle_ok = 1'b1;
    end
    repeat (20) @(negedge clk);
    checks = checks + 2;
    if (!idle_ok || lif.busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL glitch_busy: busy=%b idle_within_10=%b required idle", lif.busy, idle_ok);
    end
    if (dv_count !== dv0 || err_count !== fe0) begin
      errors = errors + 1;
      $display("FAIL glitch_pulses: dv=%0d fe=%0d required 0 0", dv_count - dv0, err_count - fe0);
    end
  endtask

  task automatic test_timeout();
    int start_dv, fall_cyc, dv0;
    logic fell;
    send_frame(12'hA5C, 1'b0, 1'b1);
    start_dv = dv_cyc;
    fell = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < 1200 && !fell; i++) begin
      @(negedge clk);
      if (lif.link_ok === 1'b0) begin
        fell = 1'b1;
        fall_cyc = cyc;
      end
    end
    checks = checks + 1;
    if (!fell || (fall_cyc - start_dv) != TO) begin
      errors = errors + 1;
      $display("FAIL timeout_fall: fell=%b after %0d cycles required %0d", fell, fall_cyc - start_dv, TO);
    end
    dv0 = dv_count;
    send_frame(12'h123, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks = checks + 2;
    if (dv_count !== dv0 + 1 || lk_at_dv !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL timeout_rise: dv=%0d link_ok_at_dv=%b required 1 1", dv_count - dv0, lk_at_dv);
    end
    if (lif.data_out !== 12'h123) begin
      errors = errors + 1;
      $display("FAIL timeout_data: data_out=%h required 123", lif.data_out);
    end
  endtask

  task automatic test_back_to_back();
    int dv0;
    logic [DW-1:0] d;
    d = 12'hABC;
    dv0 = dv_count;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(d[i]);
    @(negedge clk);
    lif.rx_in = d[5];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    lif.rx_in = 1'b1;
    checks = checks + 1;
    if ({lif.data_out, lif.data_valid, lif.frame_err, lif.link_ok, lif.busy} !== '0) begin
      errors = errors + 1;
      $display("FAIL midreset_outs: data_out=%h dv=%b fe=%b lk=%b busy=%b required all 0",
               lif.data_out, lif.data_valid, lif.frame_err, lif.link_ok, lif.busy);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks = checks + 2;
    if (lif.busy !== 1'b0 || dv_count !== dv0) begin
      errors = errors + 1;
      $display("FAIL midreset_idle: busy=%b dv=%0d required 0 0", lif.busy, dv_count - dv0);
    end
    if (lif.data_out !== 12'h000) begin
      errors = errors + 1;
      $display("FAIL midreset_data: data_out=%h required 000", lif.data_out);
    end
    send_frame(12'hFFF, 1'b0, 1'b1);
    send_frame(12'h0F0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks = checks + 2;
    if (dv_count !== dv0 + 2) begin
      errors = errors + 1;
      $display("FAIL b2b_count: pulses=%0d required 2", dv_count - dv0);
    end
    if (lif.data_out !== 12'h0F0) begin
      errors = errors + 1;
      $display("FAIL b2b_data: data_out=%h required 0f0", lif.data_out);
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    dv_count = 0; err_count = 0; dv_cyc = 0; lk_at_dv = 1'b0;
    test_reset();
    test_parity_error();
    test_good_frame();
    test_stop_fail();
    test_glitch();
    test_timeout();
    test_back_to_back();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain: %0d words left required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/link_frame_rx.md
# link_frame_rx

Serial frame receiver for the inter-board link that joins the master and slave Basys boards. The far board's transmitter drives one Pmod pin with idle-high, start-bit-framed words. Master boards carry 10-bit keyboard words and slave boards carry 12-bit health words. This block sits between the raw input pin and the game logic: it synchronises the line, recovers frames, checks parity and stop bits, and holds the last good word along with a link-alive indication.

## Interface
Parameters:
- `DATA_W`, default 12: payload bits per frame. Use 12 for health words and 10 for keyboard words.
- `CLKS_PER_BIT`, default 1000: clk cycles per bit (100 kbit/s at 100 MHz). Must be even and ≥ 8.
- `TIMEOUT_CLKS`, default 10_000_000: cycles with no good frame before `link_ok` drops (100 ms).

Ports:
- `clk`, input, 1: 100 MHz system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `rx_in`, input, 1: raw, asynchronous link pin (JXADC bit).
- `data_out`, output, DATA_W: last good payload. Held until the next good frame.
- `data_valid`, output, 1: one-cycle pulse when `data_out` updates.
- `frame_err`, output, 1: one-cycle pulse on a parity or stop-bit failure.
- `link_ok`, output, 1: high while good frames arrive within `TIMEOUT_CLKS`.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Frame format:** start bit (0), then DATA_W bits LSB first, then an even-parity bit, then a stop bit (1). The parity bit is chosen so that the data bits plus parity have an even number of ones.
- **Input synchronisation:** `rx_in` passes through a 2-flop synchroniser, then one more register (`rx_prev`) for edge detection.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** on `rx_prev`=1 and synchronised=0 (falling edge), clear the bit timer and go to START.
- **START:** at timer = CLKS_PER_BIT/2 − 1, sample the line.
  - If the sample is 1, it was a glitch: return to IDLE with no pulse.
  - If 0, clear the timer and bit index, then go to DATA.
- **DATA:** at timer = CLKS_PER_BIT − 1, sample the line into shift-register bit [index] and clear the timer. After bit DATA_W−1, go to PARITY.
- **PARITY:** sample one bit, then go to STOP.
- **STOP:** sample one bit. A frame is good when the stop bit is 1 and the XOR of the data bits and parity is 0.
  - Good frame: load `data_out`, pulse `data_valid`, clear the timeout counter.
  - Otherwise: pulse `frame_err` and leave `data_out` unchanged.
  - Either way, go to IDLE.
- **Re-arming:** IDLE only re-arms on a falling edge. After a stop-bit failure with the line stuck low, no new frame starts until the line returns high and falls again.
- **Timeout counter:** saturates at TIMEOUT_CLKS.
  - `link_ok` = 1 after a good frame.
  - `link_ok` = 0 when the counter reaches TIMEOUT_CLKS.
  - A good frame in the same cycle as expiry wins: `link_ok` stays 1 and the counter clears.
- **Counter widths:** timer is $clog2(CLKS_PER_BIT), index is $clog2(DATA_W+1), timeout is $clog2(TIMEOUT_CLKS+1).
- **Reset (any cycle, including mid-frame):**
  - FSM returns to IDLE and any partial frame is discarded.
  - `data_out`=0, `data_valid`=0, `frame_err`=0, `link_ok`=0, `busy`=0.
  - Timeout counter=0, and the synchroniser flops are preset to 1.

## Timing
- **Edge detection:** a line fall at the pin is recognised 2–3 cycles later; call that recognition cycle E.
- **Sample points:** E + CLKS_PER_BIT/2 + k·CLKS_PER_BIT, where:
  - k = 0 is the start bit,
  - k = 1..DATA_W are the data bits,
  - k = DATA_W+1 is parity,
  - k = DATA_W+2 is stop.
- **Result outputs:** `data_valid`, `frame_err` and the `data_out` update are registered. They appear the cycle after the stop sample, and `data_valid` coincides with the new `data_out`.
- **Back-to-back frames:** the FSM is in IDLE one cycle after the stop sample, about CLKS_PER_BIT/2 before the stop bit ends, so a frame can follow immediately.
- **Mutual exclusion:** `data_valid` and `frame_err` are never high in the same cycle.
- **Clock tolerance:** tolerates ±2 % clock mismatch between the boards.

## Test plan
Settings: CLKS_PER_BIT=16, DATA_W=12, TIMEOUT_CLKS=1000.
- **Good frame:** send 12'hA5C with parity 0 → one `data_valid` pulse, `data_out`=12'hA5C, `link_ok`=1, `frame_err` never high.
- **Parity error:** send 12'hA5C with parity bit 1 → one `frame_err` pulse, `data_out` stays at its previous value (0 after reset), no `data_valid`.
- **Stop-bit failure and recovery:** send a frame with stop=0 and hold the line low 40 cycles → `frame_err`, `busy`=0, and no new frame starts. Release the line high, then send 12'h001 (parity 1) → `data_out`=12'h001.
- **Glitch rejection:** drive `rx_in` low for 4 cycles from idle → no pulses, and `busy` drops back to 0 within 10 cycles.
- **Timeout:** after a good frame, keep the line idle-high → `link_ok` falls exactly TIMEOUT_CLKS cycles after the `data_valid` cycle. Send another good frame → `link_ok` rises with `data_valid`.
- **Reset mid-frame and back-to-back:** assert `reset` during data bit 5 → all outputs 0, FSM in IDLE. Then send 12'hFFF (parity 0) followed immediately by 12'h0F0 (parity 0) → two `data_valid` pulses with `data_out` 12'hFFF then 12'h0F0.
